pll_reset_sequencer: RTL and testbench

//  Sits directly downstream of the system PLL: takes its asynchronous 'locked' flag into
//  the 32 MHz core clock domain, requires it to stay stable for a qualifying period,

---
 rtl/pll_reset_sequencer.sv | 137 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Brings the core out of reset once the system PLL has proven stable. The
//   asynchronous PLL lock flag is synchronised into clk, must stay high for
//   LOCK_CYCLES consecutive cycles, and then the system reset and the CPU reset
//   are released in that order, STAGE_GAP cycles apart. In RUN the block emits
//   a one-cycle CPU clock enable every CE_DIV cycles and counts lock losses.
//
// Ports
//   clk            core clock (PLL output)
//   rst_n          asynchronous active-low reset
//   pll_locked     PLL lock flag, asynchronous to clk
//   sys_rst_out    active-high reset for RAM/video/peripherals
//   cpu_rst_out    active-high reset for the CPU core
//   cpu_ce         one-cycle CPU clock enable, every CE_DIV cycles in RUN
//   ready          high only in RUN
//   lock_drop_cnt  lock losses seen while in RUN, saturating at 255
//
// State table
//   WAIT_LOCK | resets asserted, waiting for synchronised lock
//   STABLE    | lock seen, qualifying for LOCK_CYCLES cycles
//   REL_SYS   | system reset released, CPU still held for STAGE_GAP cycles
//   RUN       | both resets released, cpu_ce running
module pll_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int STAGE_GAP   = 16,
    parameter int CE_DIV      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       sys_rst_out,
    output logic       cpu_rst_out,
    output logic       cpu_ce,
    output logic       ready,
    output logic [7:0] lock_drop_cnt
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABLE    = 2'd1;
    localparam logic [1:0] REL_SYS   = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [GAP_W-1:0]       gap;
    logic [DIV_W-1:0]       div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            gap           <= '0;
            div           <= '0;
            sys_rst_out   <= 1'b1;
            cpu_rst_out   <= 1'b1;
            cpu_ce        <= 1'b0;
            ready         <= 1'b0;
            lock_drop_cnt <= '0;
        end else if (state != WAIT_LOCK && !lock_s) begin
            // Any loss of lock drops straight back to full reset; a glitch in
            // STABLE throws away all qualification progress.
            state       <= WAIT_LOCK;
            cnt         <= '0;
            gap         <= '0;
            div         <= '0;
            sys_rst_out <= 1'b1;
            cpu_rst_out <= 1'b1;
            cpu_ce      <= 1'b0;
            ready       <= 1'b0;
            if (state == RUN && lock_drop_cnt != 8'hFF) begin
                lock_drop_cnt <= lock_drop_cnt + 8'd1;
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end
                end
                STABLE: begin
                    if (cnt == CNT_LAST) begin
                        state       <= REL_SYS;
                        sys_rst_out <= 1'b0;
                        gap         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REL_SYS: begin
                    if (gap == GAP_LAST) begin
                        state       <= RUN;
                        cpu_rst_out <= 1'b0;
                        ready       <= 1'b1;
                        div         <= '0;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                RUN: begin
                    if (div == DIV_LAST) begin
                        div    <= '0;
                        cpu_ce <= 1'b1;
                    end else begin
                        div    <= div + 1'b1;
                        cpu_ce <= 1'b0;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed table of the power-up timeline,
// hand-written corner sequences, and a randomized lock pattern checked against
// a streak-counting reference model.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int LOCK = 8;
    localparam int GAP  = 4;
    localparam int CED  = 4;
    // Number of consecutive lock-seen FSM edges after which each milestone holds.
    localparam int SYS_AT = 1 + LOCK;
    localparam int RUN_AT = 1 + LOCK + GAP;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       sys_rst_out;
    logic       cpu_rst_out;
    logic       cpu_ce;
    logic       ready;
    logic [7:0] lock_drop_cnt;

    int total = 0;
    int bad   = 0;
    int cur   = -1;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC),
        .LOCK_CYCLES(LOCK),
        .STAGE_GAP  (GAP),
        .CE_DIV     (CED)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sys_rst_out  (sys_rst_out),
        .cpu_rst_out  (cpu_rst_out),
        .cpu_ce       (cpu_ce),
        .ready        (ready),
        .lock_drop_cnt(lock_drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the FSM sees pll_locked as sampled SYNC edges earlier.
    // Everything follows from how many consecutive edges it has seen lock high.
    bit m_q[$];
    int m_streak;
    int m_drops;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = {};
            for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
            m_streak = 0;
            m_drops  = 0;
        end else begin
            bit seen;
            seen = m_q.pop_front();
            m_q.push_back(pll_locked);
            if (seen) begin
                m_streak++;
            end else begin
                if (m_streak >= RUN_AT && m_drops < 255) m_drops++;
                m_streak = 0;
            end
        end
    end

    // CPU must never be out of reset while the system is still held.
    always @(sys_rst_out or cpu_rst_out) begin
        if (rst_n === 1'b1 && cpu_rst_out === 1'b0 && sys_rst_out !== 1'b0) begin
            bad++;
            $display("FAIL order: cpu_rst_out=0 while sys_rst_out=%b at %0t", sys_rst_out, $time);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic s, input logic c,
                           input logic ce, input logic r);
        chk({name, ".sys"},   8'(sys_rst_out), 8'(s));
        chk({name, ".cpu"},   8'(cpu_rst_out), 8'(c));
        chk({name, ".ce"},    8'(cpu_ce),      8'(ce));
        chk({name, ".ready"}, 8'(ready),       8'(r));
    endtask

    // Advance to the negedge after posedge number e (S0 is the first posedge
    // after rst_n release).
    task automatic go_to(input int e);
        if (e > cur) begin
            repeat (e - cur) @(posedge clk);
            cur = e;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset(input logic lk);
        rst_n      = 1'b0;
        pll_locked = lk;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cur   = -1;
    endtask

    typedef struct {
        int   edge_n;
        logic sys;
        logic cpu;
        logic ce;
        logic rdy;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{0,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{9,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{10, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{13, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{14, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{17, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{18, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{19, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{21, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{22, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{23, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{26, 1'b0, 1'b0, 1'b1, 1'b1};

        // Power-up timeline and clock-enable cadence.
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        chk_out("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset.drops", lock_drop_cnt, 8'd0);
        rst_n = 1'b1;
        cur   = -1;
        for (int i = 0; i < 13; i++) begin
            go_to(tbl[i].edge_n);
            chk_out($sformatf("seq.S%0d", tbl[i].edge_n), tbl[i].sys, tbl[i].cpu,
                    tbl[i].ce, tbl[i].rdy);
        end

        // One-cycle lock glitch during qualification restarts it in full.
        apply_reset(1'b1);
        go_to(5);
        pll_locked = 1'b0;
        go_to(6);
        pll_locked = 1'b1;
        go_to(10);
        chk("glitch.S10.sys", 8'(sys_rst_out), 8'd1);
        go_to(16);
        chk("glitch.S16.sys", 8'(sys_rst_out), 8'd1);
        go_to(17);
        chk("glitch.S17.sys", 8'(sys_rst_out), 8'd0);
        chk("glitch.drops", lock_drop_cnt, 8'd0);

        // Lock loss in RUN, then relock with identical timing.
        apply_reset(1'b1);
        go_to(20);
        pll_locked = 1'b0;
        go_to(22);
        chk("loss.S22.ready", 8'(ready), 8'd1);
        go_to(23);
        chk_out("loss.S23", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("loss.drops", lock_drop_cnt, 8'd1);
        pll_locked = 1'b1;
        go_to(33);
        chk("relock.S33.sys", 8'(sys_rst_out), 8'd1);
        go_to(34);
        chk_out("relock.S34", 1'b0, 1'b1, 1'b0, 1'b0);
        go_to(37);
        chk("relock.S37.cpu", 8'(cpu_rst_out), 8'd1);
        go_to(38);
        chk_out("relock.S38", 1'b0, 1'b0, 1'b0, 1'b1);
        go_to(42);
        chk("relock.S42.ce", 8'(cpu_ce), 8'd1);
        chk("relock.drops", lock_drop_cnt, 8'd1);

        // Saturation of the drop counter.
        apply_reset(1'b0);
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            repeat (16) @(negedge clk);
            pll_locked = 1'b0;
            repeat (4) @(negedge clk);
            if (i == 99)  chk("sat.100", lock_drop_cnt, 8'd100);
            if (i == 254) chk("sat.255", lock_drop_cnt, 8'd255);
        end
        chk("sat.300", lock_drop_cnt, 8'd255);

        // Asynchronous reset during REL_SYS, counter cleared too.
        pll_locked = 1'b1;
        repeat (12) @(negedge clk);
        chk("relsys.sys", 8'(sys_rst_out), 8'd0);
        chk("relsys.cpu", 8'(cpu_rst_out), 8'd1);
        chk("relsys.drops", lock_drop_cnt, 8'd255);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("async_rst.drops", lock_drop_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized lock pattern against the reference model.
        apply_reset(1'b0);
        begin
            int hold;
            hold = 0;
            for (int i = 0; i < 4000; i++) begin
                @(negedge clk);
                chk("rnd.sys",   8'(sys_rst_out), 8'(m_streak < SYS_AT));
                chk("rnd.cpu",   8'(cpu_rst_out), 8'(m_streak < RUN_AT));
                chk("rnd.ready", 8'(ready),       8'(m_streak >= RUN_AT));
                chk("rnd.ce",    8'(cpu_ce),
                    8'(m_streak > RUN_AT && ((m_streak - RUN_AT) % CED) == 0));
                chk("rnd.drops", lock_drop_cnt, 8'(m_drops));
                if (i == 2000) begin
                    #1 rst_n = 1'b0;
                    #1 rst_n = 1'b1;
                end
                if (hold == 0) begin
                    pll_locked = ($urandom_range(0, 3) != 0);
                    hold = pll_locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 4));
                end
                hold--;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
